stereo_pan_mixer: RTL

Time-multiplexed multi-voice stereo panner that replaces the single-input mono-to-stereo splitter. It accepts one signed sample per voice plus a per-voice pan position and accumulates the voices serially through a single multiplier pair. It produces a saturated left/right sample pair for the codec output stage. An optional triangle-wave auto-pan LFO can override all pan positions.

---
 rtl/stereo_pan_mixer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stereo_pan_mixer.sv
// stereo_pan_mixer: time-multiplexed multi-voice stereo panner.
// Mixes VOICES mono samples into a saturated left/right pair,
// one voice per cycle through a single multiplier pair.
// Ports: clk, reset (async, active-high), sample_valid,
//   codec_sample[VOICES*WIDTH], pan[VOICES*PAN_BITS],
//   autopan (only with STEREO_PAN_AUTOPAN_EN),
//   busy, out_valid, codec_sample_left/right[WIDTH].
// Optional feature macro: STEREO_PAN_AUTOPAN_EN adds a triangle
// auto-pan LFO that overrides every voice's pan when autopan=1.
module stereo_pan_mixer #(
    parameter int WIDTH    = 16,
    parameter int VOICES   = 4,
    parameter int PAN_BITS = 8,
    parameter int LFO_STEP = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic [VOICES*WIDTH-1:0]      codec_sample,
    input  logic [VOICES*PAN_BITS-1:0]   pan,
`ifdef STEREO_PAN_AUTOPAN_EN
    input  logic                         autopan,
`endif
    output logic                         busy,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             codec_sample_left,
    output logic [WIDTH-1:0]             codec_sample_right
);

    localparam int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int PROD_W = WIDTH + PAN_BITS + 1;
    localparam int ACC_W  = PROD_W + $clog2(VOICES);

    localparam logic [PAN_BITS-1:0] PAN_MAX = '1;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [VOICES-1:0][WIDTH-1:0]    r_samp;
    logic [VOICES-1:0][PAN_BITS-1:0] r_pan;
    logic [IDX_W-1:0]                r_idx;
    logic signed [ACC_W-1:0]         r_acc_l;
    logic signed [ACC_W-1:0]         r_acc_r;
    logic                            r_busy;
    logic                            r_out_valid;
    logic [WIDTH-1:0]                r_left;
    logic [WIDTH-1:0]                r_right;

    logic [VOICES-1:0][PAN_BITS-1:0] w_pan_eff;
    logic [WIDTH-1:0]                w_s;
    logic [PAN_BITS-1:0]             w_p;
    logic signed [PROD_W-1:0]        w_prod_l;
    logic signed [PROD_W-1:0]        w_prod_r;
    logic signed [ACC_W-1:0]         w_sh_l;
    logic signed [ACC_W-1:0]         w_sh_r;

`ifdef STEREO_PAN_AUTOPAN_EN
    localparam logic [PAN_BITS:0] STEP = (PAN_BITS + 1)'(LFO_STEP);

    logic [PAN_BITS-1:0] r_lfo;
    logic                r_lfo_up;

    assign w_pan_eff = autopan ? {VOICES{r_lfo}} : pan;

    // Triangle LFO: clamps at the rails and turns around there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfo    <= '0;
            r_lfo_up <= 1'b1;
        end else if (r_state == DONE) begin
            if (r_lfo_up) begin
                if ({1'b0, r_lfo} + STEP >= {1'b0, PAN_MAX}) begin
                    r_lfo    <= PAN_MAX;
                    r_lfo_up <= 1'b0;
                end else begin
                    r_lfo <= r_lfo + STEP[PAN_BITS-1:0];
                end
            end else begin
                if ({1'b0, r_lfo} <= STEP) begin
                    r_lfo    <= '0;
                    r_lfo_up <= 1'b1;
                end else begin
                    r_lfo <= r_lfo - STEP[PAN_BITS-1:0];
                end
            end
        end
    end
`else
    assign w_pan_eff = pan;
`endif

    // Gains are zero-extended so full-scale pan stays positive.
    assign w_s      = r_samp[r_idx];
    assign w_p      = r_pan[r_idx];
    assign w_prod_l = $signed(PROD_W'($signed(w_s)))
                    * $signed(PROD_W'(PAN_MAX - w_p));
    assign w_prod_r = $signed(PROD_W'($signed(w_s)))
                    * $signed(PROD_W'(w_p));
    assign w_sh_l   = r_acc_l >>> PAN_BITS;
    assign w_sh_r   = r_acc_r >>> PAN_BITS;

    function automatic logic [WIDTH-1:0] sat(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] c;
        c = v;
        if (v > SAT_MAX) c = SAT_MAX;
        if (v < SAT_MIN) c = SAT_MIN;
        return c[WIDTH-1:0];
    endfunction

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (sample_valid) w_next = ACCUM;
            ACCUM: if (r_idx == IDX_W'(VOICES - 1)) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_samp      <= '0;
            r_pan       <= '0;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
        end else begin
            r_state     <= w_next;
            // busy trails the state by one cycle so it covers the
            // output-write cycle as well.
            r_busy      <= (r_state != IDLE);
            r_out_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_samp  <= codec_sample;
                        r_pan   <= w_pan_eff;
                        r_idx   <= '0;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                    end
                end
                ACCUM: begin
                    r_acc_l <= r_acc_l + ACC_W'(w_prod_l);
                    r_acc_r <= r_acc_r + ACC_W'(w_prod_r);
                    r_idx   <= r_idx + IDX_W'(1);
                end
                DONE: begin
                    r_left      <= sat(w_sh_l);
                    r_right     <= sat(w_sh_r);
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy               = r_busy;
    assign out_valid          = r_out_valid;
    assign codec_sample_left  = r_left;
    assign codec_sample_right = r_right;

endmodule
